// File: rtl/array_rf_sched.sv
// Refresh scheduler: paces refresh ticks, tracks refresh debt and raises
// normal or urgent refresh requests toward the array state controller.
module array_rf_sched #(
    parameter int unsigned RF_PERIOD_WIDTH = 25,
    parameter int unsigned DEBT_WIDTH      = 4,
    parameter int unsigned MAX_DEBT        = 8,
    parameter int unsigned URGENT_TH       = 4,
    parameter int unsigned IDLE_WIN        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mc_en,
    input  logic                       rf_period_sel,
    input  logic [RF_PERIOD_WIDTH-1:0] rf_period_0,
    input  logic [RF_PERIOD_WIDTH-1:0] rf_period_1,
    input  logic                       array_idle,
    output logic                       rf_req,
    output logic                       rf_urgent,
    input  logic                       rf_grant,
    input  logic                       rf_done,
    output logic [DEBT_WIDTH-1:0]      rf_debt,
    output logic                       rf_overflow,
    input  logic                       rf_overflow_clr
);

    localparam int unsigned IDLE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [RF_PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDLE_W-1:0]          idle_q, idle_d;
    logic [DEBT_WIDTH-1:0]      debt_q, debt_d;
    logic                       ovf_q, ovf_d;

    logic [RF_PERIOD_WIDTH-1:0] period_c;
    logic                       tick_c;
    logic                       done_acc_c;
    logic                       at_max_c;

    // Period compare is live, so a shortened period fires on the next cycle.
    always_comb begin
        period_c   = rf_period_sel ? rf_period_0 : rf_period_1;
        tick_c     = mc_en && (cnt_q >= period_c);
        done_acc_c = rf_done && (state_q == ST_ACTIVE);
        at_max_c   = (debt_q == DEBT_WIDTH'(MAX_DEBT));
    end

    always_comb begin
        cnt_d  = cnt_q;
        idle_d = idle_q;
        if (!mc_en) begin
            cnt_d  = '0;
            idle_d = '0;
        end else begin
            cnt_d = tick_c ? '0 : cnt_q + RF_PERIOD_WIDTH'(1);
            if (!array_idle) begin
                idle_d = '0;
            end else if (idle_q != IDLE_W'(IDLE_WIN)) begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    // A tick and an accepted completion in the same cycle cancel out.
    always_comb begin
        debt_d = debt_q;
        if (tick_c && !done_acc_c) begin
            if (!at_max_c) begin
                debt_d = debt_q + DEBT_WIDTH'(1);
            end
        end else if (done_acc_c && !tick_c && (debt_q != '0)) begin
            debt_d = debt_q - DEBT_WIDTH'(1);
        end
        if (!mc_en && ((state_q != ST_ACTIVE) || done_acc_c)) begin
            debt_d = '0;
        end
        ovf_d = (tick_c && !done_acc_c && at_max_c) || (ovf_q && !rf_overflow_clr);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mc_en && (debt_q != '0)) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!mc_en) begin
                    state_d = ST_IDLE;
                end else if (rf_grant) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (rf_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idle_q  <= '0;
            debt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            debt_q  <= debt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Request decode uses registered state only; the idle window drops the
    // cycle after array_idle falls because idle_q clears.
    always_comb begin
        rf_urgent   = (state_q == ST_PEND) && (debt_q >= DEBT_WIDTH'(URGENT_TH));
        rf_req      = (state_q == ST_PEND) && (rf_urgent || (idle_q == IDLE_W'(IDLE_WIN)));
        rf_debt     = debt_q;
        rf_overflow = ovf_q;
    end

endmodule

// File: tb/tb_array_rf_sched.sv
// Bench for array_rf_sched: directed scenarios plus random traffic, checked
// against a cycle-level behavioural model of the refresh scheduling rules.
module tb_array_rf_sched;

    localparam int unsigned PW   = 25;
    localparam int unsigned DW   = 4;
    localparam int          MAXD = 8;
    localparam int          URG  = 4;
    localparam int          WIN  = 16;

    localparam int M_IDLE = 0;
    localparam int M_PEND = 1;
    localparam int M_ACT  = 2;

    logic          clk;
    logic          rst_n;
    logic          mc_en;
    logic          sel;
    logic [PW-1:0] p0;
    logic [PW-1:0] p1;
    logic          array_idle;
    logic          rf_req;
    logic          rf_urgent;
    logic          rf_grant;
    logic          rf_done;
    logic [DW-1:0] rf_debt;
    logic          rf_overflow;
    logic          clr;

    int total;
    int bad;

    // Behavioural model state
    int m_cnt;
    int m_idle;
    int m_debt;
    int m_st;
    bit m_ovf;

    array_rf_sched #(
        .RF_PERIOD_WIDTH(PW),
        .DEBT_WIDTH     (DW),
        .MAX_DEBT       (MAXD),
        .URGENT_TH      (URG),
        .IDLE_WIN       (WIN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mc_en          (mc_en),
        .rf_period_sel  (sel),
        .rf_period_0    (p0),
        .rf_period_1    (p1),
        .array_idle     (array_idle),
        .rf_req         (rf_req),
        .rf_urgent      (rf_urgent),
        .rf_grant       (rf_grant),
        .rf_done        (rf_done),
        .rf_debt        (rf_debt),
        .rf_overflow    (rf_overflow),
        .rf_overflow_clr(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_urg();
        return (m_st == M_PEND) && (m_debt >= URG);
    endfunction

    function automatic bit exp_req();
        return (m_st == M_PEND) && (exp_urg() || (m_idle == WIN));
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_idle = 0;
        m_debt = 0;
        m_st   = M_IDLE;
        m_ovf  = 1'b0;
    endtask

    task automatic model_update();
        int per;
        int nd;
        int ns;
        bit tick;
        bit dacc;
        per  = sel ? int'(p0) : int'(p1);
        tick = mc_en && (m_cnt >= per);
        dacc = rf_done && (m_st == M_ACT);
        m_ovf = (tick && !dacc && (m_debt == MAXD)) || (m_ovf && !clr);
        nd = m_debt + (tick ? 1 : 0) - (dacc ? 1 : 0);
        if (nd > MAXD) nd = MAXD;
        if (nd < 0) nd = 0;
        ns = m_st;
        if (m_st == M_IDLE && mc_en && m_debt > 0) ns = M_PEND;
        else if (m_st == M_PEND && !mc_en) ns = M_IDLE;
        else if (m_st == M_PEND && rf_grant) ns = M_ACT;
        else if (m_st == M_ACT && rf_done) ns = M_IDLE;
        if (!mc_en) begin
            m_cnt  = 0;
            m_idle = 0;
            if (m_st != M_ACT || dacc) nd = 0;
        end else begin
            m_cnt  = tick ? 0 : m_cnt + 1;
            m_idle = array_idle ? ((m_idle + 1 > WIN) ? WIN : m_idle + 1) : 0;
        end
        m_debt = nd;
        m_st   = ns;
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_update();
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        mc_en      = 1'b0;
        sel        = 1'b0;
        p0         = '0;
        p1         = '0;
        array_idle = 1'b0;
        rf_grant   = 1'b0;
        rf_done    = 1'b0;
        clr        = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mc_en = 1'b1; sel = 1'b0; p0 = '0; p1 = '0;
        array_idle = 1'b1; rf_grant = 1'b0; rf_done = 1'b0; clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        total++; if (rf_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", rf_req); end
        total++; if (rf_urgent !== 1'b0) begin bad++; $display("FAIL reset_urg got=%b want=0", rf_urgent); end
        total++; if (rf_debt !== DW'(0)) begin bad++; $display("FAIL reset_debt got=%0d want=0", rf_debt); end
        total++; if (rf_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", rf_overflow); end
    endtask

    task automatic test_tick_idle();
        do_reset();
        mc_en = 1'b1; sel = 1'b1; p0 = PW'(9); p1 = '0; array_idle = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            step();
            total++; if (rf_debt !== DW'(m_debt)) begin bad++; $display("FAIL tick_debt cyc=%0d got=%0d want=%0d", i, rf_debt, m_debt); end
            total++; if (rf_urgent !== 1'b0) begin bad++; $display("FAIL tick_urg cyc=%0d got=%b want=0", i, rf_urgent); end
            if (i == 9) begin
                total++; if (rf_debt !== DW'(0)) begin bad++; $display("FAIL tick_before got=%0d want=0", rf_debt); end
            end
            if (i == 10) begin
                total++; if (rf_debt !== DW'(1)) begin bad++; $display("FAIL tick_first got=%0d want=1", rf_debt); end
            end
            if (i == 15) begin
                total++; if (rf_req !== 1'b0) begin bad++; $display("FAIL idle_win_early got=%b want=0", rf_req); end
            end
            if (i == 16) begin
                total++; if (rf_req !== 1'b1) begin bad++; $display("FAIL idle_win_req got=%b want=1", rf_req); end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mc_en = 1'b1; sel = 1'b0; p1 = '0; array_idle = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            total++; if (rf_debt !== DW'(m_debt)) begin bad++; $display("FAIL sat_debt cyc=%0d got=%0d want=%0d", i, rf_debt, m_debt); end
            if (i == 4) begin
                total++; if (rf_debt !== DW'(4) || rf_urgent !== 1'b1) begin bad++; $display("FAIL sat_urgent got debt=%0d urg=%b want debt=4 urg=1", rf_debt, rf_urgent); end
            end
            if (i == 8) begin
                total++; if (rf_overflow !== 1'b0 || rf_debt !== DW'(8)) begin bad++; $display("FAIL sat_full got ovf=%b debt=%0d want ovf=0 debt=8", rf_overflow, rf_debt); end
            end
            if (i == 9) begin
                total++; if (rf_overflow !== 1'b1 || rf_debt !== DW'(8)) begin bad++; $display("FAIL sat_ovf got ovf=%b debt=%0d want ovf=1 debt=8", rf_overflow, rf_debt); end
            end
        end
        clr = 1'b1;
        step();
        total++; if (rf_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b want=1", rf_overflow); end
        clr = 1'b0; mc_en = 1'b0;
        step(2);
        total++; if (rf_overflow !== 1'b1 || rf_debt !== DW'(0)) begin bad++; $display("FAIL ovf_mc_en got ovf=%b debt=%0d want ovf=1 debt=0", rf_overflow, rf_debt); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if (rf_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", rf_overflow); end
    endtask

    task automatic test_done_tick();
        int guard;
        do_reset();
        mc_en = 1'b1; sel = 1'b0; p1 = PW'(4); array_idle = 1'b0;
        guard = 0;
        while (!(m_st == M_PEND && m_debt == 2) && guard < 100) begin step(); guard++; end
        rf_grant = 1'b1;
        step();
        rf_grant = 1'b0;
        guard = 0;
        while (!(m_st == M_ACT && m_debt == 3 && m_cnt >= 4) && guard < 100) begin step(); guard++; end
        total++; if (guard >= 100) begin bad++; $display("FAIL done_tick_setup timeout got=%0d want<100", guard); end
        rf_done = 1'b1;
        step();
        rf_done = 1'b0;
        total++; if (rf_debt !== DW'(3)) begin bad++; $display("FAIL done_tick_debt got=%0d want=3", rf_debt); end
        total++; if (rf_req !== 1'b0 || rf_urgent !== 1'b0) begin bad++; $display("FAIL done_tick_idle got req=%b urg=%b want 0 0", rf_req, rf_urgent); end
        guard = 0;
        while (m_debt != 4 && guard < 20) begin step(); guard++; end
        total++; if (rf_urgent !== 1'b1 || rf_debt !== DW'(4)) begin bad++; $display("FAIL done_tick_pend got urg=%b debt=%0d want urg=1 debt=4", rf_urgent, rf_debt); end
    endtask

    task automatic test_idle_drop();
        int guard;
        do_reset();
        mc_en = 1'b1; sel = 1'b1; p0 = PW'(19); array_idle = 1'b1;
        guard = 0;
        while (!exp_req() && guard < 60) begin step(); guard++; end
        total++; if (rf_req !== 1'b1 || rf_urgent !== 1'b0) begin bad++; $display("FAIL drop_pre got req=%b urg=%b want req=1 urg=0", rf_req, rf_urgent); end
        array_idle = 1'b0;
        step();
        total++; if (rf_req !== 1'b0) begin bad++; $display("FAIL drop_req got=%b want=0", rf_req); end
        array_idle = 1'b1;
        step(15);
        total++; if (rf_req !== 1'b0) begin bad++; $display("FAIL drop_idle_cnt got=%b want=0", rf_req); end
        step();
        total++; if (rf_req !== 1'b1) begin bad++; $display("FAIL drop_rearm got=%b want=1", rf_req); end
    endtask

    task automatic test_mc_en_active();
        int guard;
        do_reset();
        mc_en = 1'b1; sel = 1'b0; p1 = '0; array_idle = 1'b0;
        guard = 0;
        while (!(m_st == M_PEND && m_debt == 4) && guard < 50) begin step(); guard++; end
        rf_grant = 1'b1;
        step();
        rf_grant = 1'b0;
        total++; if (rf_debt !== DW'(5)) begin bad++; $display("FAIL act_debt got=%0d want=5", rf_debt); end
        mc_en = 1'b0;
        step(3);
        total++; if (rf_debt !== DW'(m_debt) || rf_req !== 1'b0 || rf_urgent !== 1'b0) begin bad++; $display("FAIL act_hold got debt=%0d req=%b urg=%b want debt=%0d req=0 urg=0", rf_debt, rf_req, rf_urgent, m_debt); end
        rf_done = 1'b1;
        step();
        rf_done = 1'b0;
        total++; if (rf_debt !== DW'(0) || rf_req !== 1'b0) begin bad++; $display("FAIL act_done got debt=%0d req=%b want debt=0 req=0", rf_debt, rf_req); end
        mc_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (rf_debt !== DW'(m_debt) || rf_urgent !== exp_urg()) begin bad++; $display("FAIL act_resume cyc=%0d got debt=%0d urg=%b want debt=%0d urg=%b", i, rf_debt, rf_urgent, m_debt, exp_urg()); end
        end
    endtask

    task automatic test_async_reset();
        int guard;
        do_reset();
        mc_en = 1'b1; sel = 1'b0; p1 = '0; array_idle = 1'b0;
        step(9);
        mc_en = 1'b0;
        step();
        mc_en = 1'b1;
        guard = 0;
        while (!(m_st == M_PEND && m_debt == 6) && guard < 50) begin step(); guard++; end
        total++; if (rf_overflow !== 1'b1 || rf_urgent !== 1'b1 || rf_debt !== DW'(6)) begin bad++; $display("FAIL arst_pre got ovf=%b urg=%b debt=%0d want 1 1 6", rf_overflow, rf_urgent, rf_debt); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (rf_req !== 1'b0 || rf_urgent !== 1'b0 || rf_debt !== DW'(0) || rf_overflow !== 1'b0) begin bad++; $display("FAIL arst_async got req=%b urg=%b debt=%0d ovf=%b want all 0", rf_req, rf_urgent, rf_debt, rf_overflow); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        p0 = PW'($urandom_range(0, 7));
        p1 = PW'($urandom_range(0, 7));
        for (int i = 0; i < 800; i++) begin
            mc_en    = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 15) == 0) sel = ~sel;
            if ($urandom_range(0, 49) == 0) begin
                p0 = PW'($urandom_range(0, 7));
                p1 = PW'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 31) == 0) array_idle = ~array_idle;
            rf_grant = ($urandom_range(0, 2) == 0);
            rf_done  = ($urandom_range(0, 3) == 0);
            clr      = ($urandom_range(0, 15) == 0);
            step();
            total++; if (rf_req !== exp_req()) begin bad++; $display("FAIL rand_req cyc=%0d got=%b want=%b", i, rf_req, exp_req()); end
            total++; if (rf_urgent !== exp_urg()) begin bad++; $display("FAIL rand_urg cyc=%0d got=%b want=%b", i, rf_urgent, exp_urg()); end
            total++; if (rf_debt !== DW'(m_debt)) begin bad++; $display("FAIL rand_debt cyc=%0d got=%0d want=%0d", i, rf_debt, m_debt); end
            total++; if (rf_overflow !== m_ovf) begin bad++; $display("FAIL rand_ovf cyc=%0d got=%b want=%b", i, rf_overflow, m_ovf); end
        end
        rf_grant = 1'b0;
        rf_done  = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_tick_idle();
        test_saturation();
        test_done_tick();
        test_idle_drop();
        test_mc_en_active();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
